// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between WB, MDU and DBG with a starvation stall
module rf_write_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WB_WRITE,
  input  logic [ADDR_W-1:0] WB_ADDR,
  input  logic [DATA_W-1:0] WB_DATA,
  input  logic              MDU_VALID,
  input  logic [ADDR_W-1:0] MDU_ADDR,
  input  logic [DATA_W-1:0] MDU_DATA,
  output logic              MDU_READY,
  input  logic              DBG_VALID,
  input  logic [ADDR_W-1:0] DBG_ADDR,
  input  logic [DATA_W-1:0] DBG_DATA,
  output logic              DBG_READY,
  output logic              STALL_REQ,
  output logic              RF_WRITE,
  output logic [ADDR_W-1:0] RF_INADDRESS,
  output logic [DATA_W-1:0] RF_IN,
  output logic [1:0]        GRANT_ID,
  output logic              PROTO_ERR
);
  typedef enum logic {NORMAL, STALL} state_t;
  localparam logic [7:0] MW = 8'(MAX_WAIT);
  state_t state, state_nx;
  logic [7:0] mcnt, dcnt, mcnt_nx, dcnt_nx;
  logic rr_mdu, stall_d, m_starve, d_starve, pick_mdu, idle, m_wait, d_wait;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  assign STALL_REQ = (state == STALL);
  // Grant selection, wait-counter update and next FSM state; a starved source overrides RR during STALL
  always_comb begin
    m_starve = mcnt >= MW;
    d_starve = dcnt >= MW;
    pick_mdu = (state == STALL && m_starve != d_starve) ? m_starve : rr_mdu;
    idle = RESET && !WB_WRITE;
    MDU_READY = idle && MDU_VALID && (!DBG_VALID || pick_mdu);
    DBG_READY = idle && DBG_VALID && (!MDU_VALID || !pick_mdu);
    m_wait = MDU_VALID && !MDU_READY;
    d_wait = DBG_VALID && !DBG_READY;
    mcnt_nx = m_wait ? mcnt + {7'b0, mcnt != 8'hFF} : 8'd0;
    dcnt_nx = d_wait ? dcnt + {7'b0, dcnt != 8'hFF} : 8'd0;
    state_nx = (state == NORMAL)
      ? (((m_starve && m_wait) || (d_starve && d_wait)) ? STALL : NORMAL)
      : ((mcnt_nx >= MW || dcnt_nx >= MW) ? STALL : NORMAL);
    sel_addr = WB_WRITE ? WB_ADDR : MDU_READY ? MDU_ADDR : DBG_ADDR;
    sel_data = WB_WRITE ? WB_DATA : MDU_READY ? MDU_DATA : DBG_DATA;
  end
  // State, counters, RR pointer, sticky error and the registered write port; the first STALL cycle tolerates WB since the pipeline cannot react yet
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state        <= NORMAL;
      mcnt         <= '0;
      dcnt         <= '0;
      rr_mdu       <= 1'b1;
      stall_d      <= 1'b0;
      PROTO_ERR    <= 1'b0;
      RF_WRITE     <= 1'b0;
      RF_INADDRESS <= '0;
      RF_IN        <= '0;
      GRANT_ID     <= 2'd0;
    end else begin
      state     <= state_nx;
      mcnt      <= mcnt_nx;
      dcnt      <= dcnt_nx;
      rr_mdu    <= MDU_READY ? 1'b0 : DBG_READY ? 1'b1 : rr_mdu;
      stall_d   <= STALL_REQ;
      PROTO_ERR <= PROTO_ERR | (WB_WRITE & STALL_REQ & stall_d);
      RF_WRITE  <= (WB_WRITE || MDU_READY || DBG_READY) && (sel_addr != '0);
      GRANT_ID  <= WB_WRITE ? 2'd1 : MDU_READY ? 2'd2 : DBG_READY ? 2'd3 : 2'd0;
      if (WB_WRITE || MDU_READY || DBG_READY) begin
        RF_INADDRESS <= sel_addr;
        RF_IN        <= sel_data;
      end
    end
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed self-checking bench for rf_write_arbiter
module tb_rf_write_arbiter;
  logic        CLK = 0, RESET = 0;
  logic        WB_WRITE = 0, MDU_VALID = 0, DBG_VALID = 0;
  logic [4:0]  WB_ADDR = 0, MDU_ADDR = 0, DBG_ADDR = 0;
  logic [31:0] WB_DATA = 0, MDU_DATA = 0, DBG_DATA = 0;
  logic        MDU_READY, DBG_READY, STALL_REQ, RF_WRITE, PROTO_ERR;
  logic [4:0]  RF_INADDRESS;
  logic [31:0] RF_IN;
  logic [1:0]  GRANT_ID;
  int checks = 0, failures = 0;

  rf_write_arbiter #(.DATA_W(32), .ADDR_W(5), .MAX_WAIT(8)) dut (
    .CLK(CLK), .RESET(RESET),
    .WB_WRITE(WB_WRITE), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
    .MDU_VALID(MDU_VALID), .MDU_ADDR(MDU_ADDR), .MDU_DATA(MDU_DATA), .MDU_READY(MDU_READY),
    .DBG_VALID(DBG_VALID), .DBG_ADDR(DBG_ADDR), .DBG_DATA(DBG_DATA), .DBG_READY(DBG_READY),
    .STALL_REQ(STALL_REQ), .RF_WRITE(RF_WRITE), .RF_INADDRESS(RF_INADDRESS), .RF_IN(RF_IN),
    .GRANT_ID(GRANT_ID), .PROTO_ERR(PROTO_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rf_chk(input string tag, input logic w, input logic [4:0] a, input logic [31:0] d, input logic [1:0] g);
    chk({tag, "_write"}, 64'(RF_WRITE), 64'(w));
    if (w) begin
      chk({tag, "_addr"}, 64'(RF_INADDRESS), 64'(a));
      chk({tag, "_data"}, 64'(RF_IN), 64'(d));
    end
    chk({tag, "_grant"}, 64'(GRANT_ID), 64'(g));
  endtask

  initial begin
    // reset held two cycles with all requesters valid
    MDU_VALID = 1; DBG_VALID = 1; MDU_ADDR = 3; DBG_ADDR = 4;
    #1;
    chk("rst_mdu_ready", 64'(MDU_READY), 0);
    chk("rst_dbg_ready", 64'(DBG_READY), 0);
    tick();
    tick();
    chk("rst_mdu_ready2", 64'(MDU_READY), 0);
    chk("rst_dbg_ready2", 64'(DBG_READY), 0);
    rf_chk("rst_rf", 0, 0, 0, 0);
    chk("rst_stall", 64'(STALL_REQ), 0);
    chk("rst_proto", 64'(PROTO_ERR), 0);
    MDU_VALID = 0; DBG_VALID = 0; RESET = 1;
    tick();
    // WB priority over a valid MDU
    WB_WRITE = 1; WB_ADDR = 5; WB_DATA = 32'h1234;
    MDU_VALID = 1; MDU_ADDR = 7; MDU_DATA = 32'h77;
    #1;
    chk("wb_prio_mdu_ready", 64'(MDU_READY), 0);
    tick();
    rf_chk("wb_prio_rf", 1, 5, 32'h1234, 1);
    WB_WRITE = 0; MDU_VALID = 0;
    tick();
    rf_chk("idle_rf", 0, 0, 0, 0);
    // round-robin, MDU first
    MDU_VALID = 1; MDU_ADDR = 3; MDU_DATA = 32'hAA;
    DBG_VALID = 1; DBG_ADDR = 4; DBG_DATA = 32'hBB;
    #1;
    chk("rr0_mdu_ready", 64'(MDU_READY), 1);
    chk("rr0_dbg_ready", 64'(DBG_READY), 0);
    tick();
    MDU_VALID = 0;
    #1;
    chk("rr1_dbg_ready", 64'(DBG_READY), 1);
    rf_chk("rr0_rf", 1, 3, 32'hAA, 2);
    tick();
    DBG_VALID = 0;
    rf_chk("rr1_rf", 1, 4, 32'hBB, 3);
    // RR pointer now favours MDU again; then check the flip with both valid
    MDU_VALID = 1; MDU_ADDR = 10; MDU_DATA = 32'h10;
    DBG_VALID = 1; DBG_ADDR = 11; DBG_DATA = 32'h11;
    #1;
    chk("rr2_mdu_ready", 64'(MDU_READY), 1);
    tick();
    MDU_VALID = 0; DBG_VALID = 0;
    rf_chk("rr2_rf", 1, 10, 32'h10, 2);
    // x0 write from DBG consumed but not written (pointer now favours DBG)
    DBG_VALID = 1; DBG_ADDR = 0; DBG_DATA = 32'hFFFF;
    #1;
    chk("x0_dbg_ready", 64'(DBG_READY), 1);
    tick();
    DBG_VALID = 0;
    rf_chk("x0_dbg_rf", 0, 0, 0, 3);
    // x0 write from WB also suppressed
    WB_WRITE = 1; WB_ADDR = 0; WB_DATA = 32'h55;
    tick();
    WB_WRITE = 0;
    rf_chk("x0_wb_rf", 0, 0, 0, 1);
    tick();
    // starvation: WB every cycle, MDU waiting from cycle 0
    WB_WRITE = 1; WB_ADDR = 9; WB_DATA = 32'h900;
    MDU_VALID = 1; MDU_ADDR = 6; MDU_DATA = 32'h66;
    for (int i = 1; i <= 8; i++) begin
      tick();
      WB_DATA = 32'h900 + 32'(i);
      chk($sformatf("starve_stall_c%0d", i), 64'(STALL_REQ), 0);
      chk($sformatf("starve_ready_c%0d", i), 64'(MDU_READY), 0);
    end
    tick();
    chk("starve_stall_c9", 64'(STALL_REQ), 1);
    rf_chk("starve_rf_c9", 1, 9, 32'h908, 1);
    tick();
    WB_WRITE = 0;
    #1;
    chk("starve_stall_c10", 64'(STALL_REQ), 1);
    chk("starve_ready_c10", 64'(MDU_READY), 1);
    tick();
    MDU_VALID = 0;
    chk("starve_stall_c11", 64'(STALL_REQ), 0);
    chk("starve_proto_c11", 64'(PROTO_ERR), 0);
    rf_chk("starve_rf_c11", 1, 6, 32'h66, 2);
    tick();
    // protocol error: WB kept high through STALL while DBG starves
    WB_WRITE = 1; WB_ADDR = 12; WB_DATA = 32'h100;
    DBG_VALID = 1; DBG_ADDR = 2; DBG_DATA = 32'h22;
    for (int i = 1; i <= 10; i++) begin
      tick();
      WB_DATA = 32'h100 + 32'(i);
    end
    chk("perr_stall_c10", 64'(STALL_REQ), 1);
    chk("perr_proto_c10", 64'(PROTO_ERR), 0);
    tick();
    WB_WRITE = 0;
    #1;
    chk("perr_proto_c11", 64'(PROTO_ERR), 1);
    chk("perr_stall_c11", 64'(STALL_REQ), 1);
    rf_chk("perr_rf_c11", 1, 12, 32'h10A, 1);
    chk("perr_dbg_ready_c11", 64'(DBG_READY), 1);
    tick();
    DBG_VALID = 0;
    chk("perr_stall_c12", 64'(STALL_REQ), 0);
    chk("perr_proto_c12", 64'(PROTO_ERR), 1);
    rf_chk("perr_rf_c12", 1, 2, 32'h22, 3);
    tick();
    chk("perr_proto_c13", 64'(PROTO_ERR), 1);
    // reset mid-operation: registered write cancelled, pending request not accepted
    MDU_VALID = 1; MDU_ADDR = 8; MDU_DATA = 32'h88;
    tick();
    MDU_VALID = 0;
    RESET = 0; DBG_VALID = 1; DBG_ADDR = 13; DBG_DATA = 32'hDD;
    #1;
    rf_chk("mid_rf_before", 1, 8, 32'h88, 2);
    chk("mid_dbg_ready", 64'(DBG_READY), 0);
    tick();
    rf_chk("mid_rf_after", 0, 0, 0, 0);
    chk("mid_proto", 64'(PROTO_ERR), 0);
    chk("mid_stall", 64'(STALL_REQ), 0);
    RESET = 1; DBG_VALID = 0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
